// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order CDB completion, in-order registered commit.
// Optional macro ROB_BYPASS_EN forwards a same-cycle CDB result into the operand lookups.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_LEN  = 4,
    parameter int DATA_LEN = 32,
    parameter int REG_LEN  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena_from_dsp,
    input  logic [REG_LEN-1:0]  rd_from_dsp,
    output logic [ROB_LEN:0]    Q_to_dsp,
    output logic                full_to_dsp,
    input  logic [ROB_LEN:0]    Q1_from_dsp,
    input  logic [ROB_LEN:0]    Q2_from_dsp,
    output logic                ready1_to_dsp,
    output logic                ready2_to_dsp,
    output logic [DATA_LEN-1:0] V1_to_dsp,
    output logic [DATA_LEN-1:0] V2_to_dsp,
    input  logic                cdb_flag,
    input  logic [ROB_LEN:0]    cdb_Q,
    input  logic [DATA_LEN-1:0] cdb_V,
    input  logic                rollback_flag,
    output logic                commit_flag_to_reg,
    output logic [REG_LEN-1:0]  rd_to_reg,
    output logic [ROB_LEN:0]    Q_to_reg,
    output logic [DATA_LEN-1:0] V_to_reg
);

    localparam logic [ROB_LEN:0]   TAG_ZERO = (ROB_LEN+1)'(0);
    localparam logic [ROB_LEN:0]   TAG_ONE  = (ROB_LEN+1)'(1);
    localparam logic [ROB_LEN:0]   TAG_MAX  = (ROB_LEN+1)'(ROB_SIZE);
    localparam logic [ROB_LEN-1:0] PTR_ONE  = ROB_LEN'(1);

    logic [ROB_SIZE-1:0] busy_r;
    logic [ROB_SIZE-1:0] ready_r;
    logic [REG_LEN-1:0]  rd_r [ROB_SIZE];
    logic [DATA_LEN-1:0] v_r  [ROB_SIZE];
    logic [ROB_LEN-1:0]  head_r;
    logic [ROB_LEN-1:0]  tail_r;
    logic [ROB_LEN:0]    count_r;

    logic                alloc_s;
    logic                cdb_hit_s;
    logic                commit_s;
    logic [ROB_LEN-1:0]  cdb_idx_s;
    logic                byp1_s;
    logic                byp2_s;

    // Tag 0 means "no producer"; tags above ROB_SIZE never name an entry.
    function automatic logic tag_valid(input logic [ROB_LEN:0] tag);
        return (tag != TAG_ZERO) && (tag <= TAG_MAX);
    endfunction

    function automatic logic [ROB_LEN-1:0] tag_index(input logic [ROB_LEN:0] tag);
        logic [ROB_LEN:0] idx;
        idx = tag - TAG_ONE;
        return idx[ROB_LEN-1:0];
    endfunction

    assign Q_to_dsp    = {1'b0, tail_r} + TAG_ONE;
    assign full_to_dsp = (count_r == TAG_MAX);
    assign alloc_s     = ena_from_dsp && !full_to_dsp;
    assign cdb_idx_s   = tag_index(cdb_Q);
    assign cdb_hit_s   = cdb_flag && tag_valid(cdb_Q) && busy_r[cdb_idx_s];
    // Commit looks only at pre-edge ready, so a same-cycle CDB write to head waits a cycle.
    assign commit_s    = (count_r != TAG_ZERO) && busy_r[head_r] && ready_r[head_r];

`ifdef ROB_BYPASS_EN
    assign byp1_s = cdb_flag && tag_valid(Q1_from_dsp) && (cdb_Q == Q1_from_dsp)
                    && busy_r[tag_index(Q1_from_dsp)];
    assign byp2_s = cdb_flag && tag_valid(Q2_from_dsp) && (cdb_Q == Q2_from_dsp)
                    && busy_r[tag_index(Q2_from_dsp)];
`else
    assign byp1_s = 1'b0;
    assign byp2_s = 1'b0;
`endif

    // Operand lookup: stored result first, then the optional live CDB forward.
    always_comb begin
        ready1_to_dsp = 1'b0;
        V1_to_dsp     = {DATA_LEN{1'b0}};
        ready2_to_dsp = 1'b0;
        V2_to_dsp     = {DATA_LEN{1'b0}};
        if (tag_valid(Q1_from_dsp) && ready_r[tag_index(Q1_from_dsp)]) begin
            ready1_to_dsp = 1'b1;
            V1_to_dsp     = v_r[tag_index(Q1_from_dsp)];
        end else if (byp1_s) begin
            ready1_to_dsp = 1'b1;
            V1_to_dsp     = cdb_V;
        end else begin
            ready1_to_dsp = 1'b0;
            V1_to_dsp     = {DATA_LEN{1'b0}};
        end
        if (tag_valid(Q2_from_dsp) && ready_r[tag_index(Q2_from_dsp)]) begin
            ready2_to_dsp = 1'b1;
            V2_to_dsp     = v_r[tag_index(Q2_from_dsp)];
        end else if (byp2_s) begin
            ready2_to_dsp = 1'b1;
            V2_to_dsp     = cdb_V;
        end else begin
            ready2_to_dsp = 1'b0;
            V2_to_dsp     = {DATA_LEN{1'b0}};
        end
    end

    // Entry storage: allocate at tail, capture CDB results, retire at head.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= {ROB_SIZE{1'b0}};
            ready_r <= {ROB_SIZE{1'b0}};
            for (int i = 0; i < ROB_SIZE; i++) begin
                v_r[i] <= {DATA_LEN{1'b0}};
            end
        end else if (rollback_flag) begin
            busy_r  <= {ROB_SIZE{1'b0}};
            ready_r <= {ROB_SIZE{1'b0}};
        end else begin
            if (alloc_s) begin
                busy_r[tail_r]  <= 1'b1;
                ready_r[tail_r] <= 1'b0;
                rd_r[tail_r]    <= rd_from_dsp;
                v_r[tail_r]     <= {DATA_LEN{1'b0}};
            end
            if (cdb_hit_s) begin
                ready_r[cdb_idx_s] <= 1'b1;
                v_r[cdb_idx_s]     <= cdb_V;
            end
            if (commit_s) begin
                busy_r[head_r]  <= 1'b0;
                ready_r[head_r] <= 1'b0;
            end
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst || rollback_flag) begin
            head_r  <= {ROB_LEN{1'b0}};
            tail_r  <= {ROB_LEN{1'b0}};
            count_r <= TAG_ZERO;
        end else begin
            head_r <= commit_s ? head_r + PTR_ONE : head_r;
            tail_r <= alloc_s  ? tail_r + PTR_ONE : tail_r;
            case ({alloc_s, commit_s})
                2'b10:   count_r <= count_r + TAG_ONE;
                2'b01:   count_r <= count_r - TAG_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered commit pulse and payload toward the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_flag_to_reg <= 1'b0;
            rd_to_reg          <= {REG_LEN{1'b0}};
            Q_to_reg           <= TAG_ZERO;
            V_to_reg           <= {DATA_LEN{1'b0}};
        end else if (rollback_flag) begin
            commit_flag_to_reg <= 1'b0;
        end else begin
            commit_flag_to_reg <= commit_s;
            if (commit_s) begin
                rd_to_reg <= rd_r[head_r];
                Q_to_reg  <= {1'b0, head_r} + TAG_ONE;
                V_to_reg  <= v_r[head_r];
            end
        end
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16, number of entries (power of two, >= 2).
REQ-002 SHALL have parameter ROB_LEN, default 4, log2(ROB_SIZE); tag width is ROB_LEN+1.
REQ-003 SHALL have parameter DATA_LEN, default 32, value width.
REQ-004 SHALL have parameter REG_LEN, default 5, architectural register index width.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 ena_from_dsp  in  1  allocate one entry this cycle.
REQ-008 rd_from_dsp  in  REG_LEN  destination register of the allocated entry.
REQ-009 Q_to_dsp  out  ROB_LEN+1  tag an allocation this cycle receives (combinational: tail+1).
REQ-010 full_to_dsp  out  1  buffer full (combinational: count == ROB_SIZE).
REQ-011 Q1_from_dsp / Q2_from_dsp  in  ROB_LEN+1  operand tags to look up.
REQ-012 ready1_to_dsp / ready2_to_dsp  out  1  looked-up entry has its result.
REQ-013 V1_to_dsp / V2_to_dsp  out  DATA_LEN  looked-up result; 0 when not ready.
REQ-014 cdb_flag  in  1  result broadcast valid.
REQ-015 cdb_Q  in  ROB_LEN+1  tag of broadcast result.
REQ-016 cdb_V  in  DATA_LEN  broadcast result value.
REQ-017 rollback_flag  in  1  flush all entries.
REQ-018 commit_flag_to_reg  out  1  registered, one-cycle commit pulse to the register file.
REQ-019 rd_to_reg / Q_to_reg / V_to_reg  out  REG_LEN / ROB_LEN+1 / DATA_LEN  registered commit payload.

Function
REQ-020 Storage SHALL be a circular buffer: per entry busy, ready, rd, V; head, tail (ROB_LEN bits, wrap mod ROB_SIZE), count (ROB_LEN+1 bits).
REQ-021 Tag encoding SHALL be index+1; tag 0 means "no producer" and never names an entry.
REQ-022 Allocation with ena_from_dsp=1 and full_to_dsp=0 SHALL write busy=1, ready=0, rd, V=0 at tail and advance tail by 1.
REQ-023 Allocation while full_to_dsp=1 SHALL be ignored; full is evaluated from pre-edge count, so same-cycle commit does not permit allocation.
REQ-024 cdb_flag=1 with cdb_Q naming a busy entry SHALL set ready=1 and V=cdb_V at that edge; tag 0 or a non-busy entry SHALL be ignored.
REQ-025 Commit: when count>0 and entry[head] has busy=1 and ready=1, at that edge commit outputs SHALL load rd, head+1, V, commit_flag_to_reg SHALL be 1, entry cleared, head advanced; else commit_flag_to_reg SHALL be 0.
REQ-026 At most one commit per cycle; entries commit strictly in allocation order.
REQ-027 Latency: CDB result in cycle N at head SHALL produce commit_flag_to_reg=1 during cycle N+2.
REQ-028 Entries with rd=0 SHALL commit normally (register file discards them).
REQ-029 count SHALL update as +alloc -commit in the same edge; simultaneous alloc and commit leaves count unchanged.
REQ-030 A CDB write to head in the same cycle as commit evaluation SHALL NOT commit that cycle (ready is pre-edge state).
REQ-031 Lookup: tag naming a ready entry SHALL return ready=1, V=entry V; tag 0 or non-ready entry SHALL return ready=0, V=0.
REQ-032 rollback_flag=1 SHALL override alloc, CDB and commit: clear all busy/ready, head=tail=count=0, commit_flag_to_reg=0 at that edge.

Reset
REQ-033 rst=1 SHALL have priority over rollback_flag and equal the rollback effect, plus rd_to_reg, Q_to_reg, V_to_reg = 0 and all entry V = 0.
REQ-034 After reset: full_to_dsp=0, Q_to_dsp=1, ready outputs 0, V outputs 0.

Configuration
REQ-035 Macro ROB_BYPASS_EN defined: lookup with cdb_flag=1 and cdb_Q equal to a busy non-ready entry's tag SHALL return ready=1, V=cdb_V in the same cycle.
REQ-036 Macro ROB_BYPASS_EN undefined: lookup SHALL reflect stored state only; such a lookup returns ready=0 until the cycle after the CDB write.

Verification
REQ-037 Reset, then alloc rd=5 -> Q_to_dsp=1 before edge, 2 after; CDB Q=1 V=0x1234 -> commit pulse two cycles later with rd=5, Q=1, V=0x1234.
REQ-038 16 allocs without CDB -> full_to_dsp=1; 17th alloc ignored; CDB Q=1 V=7 then commit -> full_to_dsp drops, next alloc gets Q=1 (wrap).
REQ-039 Alloc tags 1,2,3; CDB Q=3 then Q=1 -> commits in order 1 (next cycle), 2 and 3 held until CDB Q=2, then 2 and 3 in consecutive cycles.
REQ-040 Lookup Q1=2 during CDB Q=2 V=0xAB -> with ROB_BYPASS_EN ready1=1 V1=0xAB; without, ready1=0 that cycle, 1 next.
REQ-041 Four entries allocated, two ready, rollback_flag=1 with simultaneous alloc and CDB -> count=0, no commit pulse, next alloc returns Q=1.
REQ-042 Full buffer, head ready, alloc and commit same cycle -> alloc refused, count becomes 15, full_to_dsp=0 next cycle.
